// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width and byte type common to spi_top and its buffers.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers, registered count and
// combinational head read. Storage is cleared on reset so the head reads zero.
module spi_sync_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// Receive buffer behind spi_top: captures one byte per rising edge of done,
// queues it in a FIFO and serves it on a valid/ready stream with sticky overflow.
module spi_rx_buffer
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_BYTE_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            rx_data,
  input  logic                         rx_done,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  logic done_q;
  logic capture;
  logic pop;
  logic drop;
  logic empty;

  assign capture = rx_done & ~done_q;
  assign pop     = m_valid & m_ready;
  assign drop    = capture & full & ~pop;
  assign m_valid = ~empty;

  spi_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (m_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Edge detect on done and sticky drop flag; a drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q <= rx_done;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule
